// File: rtl/joypad_pkg.sv
// Shared constants, filter state type and P1 nibble helper for the Game Boy joypad controller.
package joypad_pkg;

  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_SELECT = 6;
  localparam int unsigned BTN_START  = 7;

  localparam int unsigned P1_SEL_DIR = 4;
  localparam int unsigned P1_SEL_ACT = 5;

  localparam logic [7:0] P1_RESET = 8'hFF;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filt_state_t;

  // Active-low P1 nibble; sel = {P15, P14}, a low select line enables its button group.
  function automatic logic [3:0] p1_nibble(input logic [7:0] btn, input logic [1:0] sel);
    logic [3:0] dir;
    logic [3:0] act;
    dir = ~btn[3:0];
    act = ~btn[7:4];
    return (sel[0] ? 4'hF : dir) & (sel[1] ? 4'hF : act);
  endfunction

endpackage

// File: rtl/joypad_if.sv
// CPU-side P1 register port of the joypad controller: write strobe/data, read data and irq.
interface joypad_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       irq;

  modport master (
    output wr_en,
    output wr_data,
    input  rd_data,
    input  irq
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output rd_data,
    output irq
  );
endinterface

// File: rtl/button_filter.sv
// One button: 2-flop synchronizer followed by a strobe-sampled debounce filter.
module button_filter
  import joypad_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CntW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_SAMPLES);

  logic [1:0]      sync_q;
  filt_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            sample;

  assign sample = sync_q[1];
  assign stable = stable_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (strobe) begin
      unique case (state_q)
        STABLE: begin
          if (sample != stable_q) begin
            if (STABLE_SAMPLES == 1) begin
              stable_d = ~stable_q;
              cnt_d    = '0;
            end else begin
              cnt_d   = CntW'(1);
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (sample == stable_q) begin
            cnt_d   = '0;
            state_d = STABLE;
          end else if (cnt_q + CntW'(1) == CntMax) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
            state_d  = STABLE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = STABLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b00;
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/joypad_ctrl.sv
// Joypad controller: sample prescaler, eight debounce filters, P1 register and joypad irq.
// Define JOYPAD_IRQ_EN to build the interrupt logic; otherwise irq is tied low.
module joypad_ctrl
  import joypad_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned STABLE_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  output logic [7:0] btn_state,
  joypad_if.slave    bus
);

  localparam int unsigned PreW = $clog2(SAMPLE_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(SAMPLE_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            strobe;
  logic [1:0]      sel_q;
  logic [3:0]      nibble;

  assign strobe = (pre_q == PreLast);

  always_comb begin
    pre_d = strobe ? '0 : pre_q + PreW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      sel_q <= P1_RESET[P1_SEL_ACT:P1_SEL_DIR];
    end else begin
      pre_q <= pre_d;
      if (bus.wr_en) begin
        sel_q <= bus.wr_data[P1_SEL_ACT:P1_SEL_DIR];
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_btn
    button_filter #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_filter (
      .clk   (clk),
      .reset (reset),
      .strobe(strobe),
      .raw   (btn_raw[i]),
      .stable(btn_state[i])
    );
  end

  always_comb begin
    nibble      = p1_nibble(btn_state, sel_q);
    bus.rd_data = {2'b11, sel_q, nibble};
  end

`ifdef JOYPAD_IRQ_EN
  logic [3:0] nib_q;
  logic       irq_q;

  // Any 1->0 nibble bit raises irq, whether from a button flip or a select write.
  always_ff @(posedge clk) begin
    if (reset) begin
      nib_q <= 4'hF;
      irq_q <= 1'b0;
    end else begin
      nib_q <= nibble;
      irq_q <= |(nib_q & ~nibble);
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: doc/joypad_ctrl.md
# joypad_ctrl

Joypad controller for the Game Boy core. It owns the eight board button inputs and drives one shared sample-strobe prescaler that schedules eight per-button debounce filters. It presents the debounced state to the CPU as the P1 register (0xFF00) with the P14/P15 select-line multiplexing, and raises the joypad interrupt request on a high-to-low transition of the P1 input nibble.

## Interface

**Parameters**
- `SAMPLE_DIV`, default 50000: clock cycles between sample strobes. Must be ≥2.
- `STABLE_SAMPLES`, default 8: number of consecutive disagreeing samples required before a stable button state flips. Must be ≥1.

**Ports**
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_raw` in 8: asynchronous board buttons, active-high. Bit order: [0]right [1]left [2]up [3]down [4]A [5]B [6]select [7]start.
- `wr_en` in 1: CPU write strobe to P1.
- `wr_data` in 8: write data. Only bits 5:4 are stored.
- `rd_data` out 8: P1 read value, combinational from registered state.
- `btn_state` out 8: debounced button state, active-high, same bit order as `btn_raw`.
- `irq` out 1: joypad interrupt request, a one-cycle pulse.

## Operation

- **Synchronizer:** each `btn_raw` bit passes through a 2-flop synchronizer before reaching its filter.
- **Prescaler:** the counter runs 0..SAMPLE_DIV-1 and wraps to 0. `strobe` is high when count == SAMPLE_DIV-1. Width is $clog2(SAMPLE_DIV).
- **Per-button filter FSM:** states STABLE and PENDING, with a counter of width $clog2(STABLE_SAMPLES+1).
  - Non-strobe cycles: filter holds its state.
  - STABLE, on strobe, sample == stable: stay in STABLE.
  - STABLE, on strobe, sample != stable: cnt=1. If STABLE_SAMPLES==1, flip stable immediately and stay in STABLE; otherwise go to PENDING.
  - PENDING, on strobe, sample == stable: go to STABLE with cnt=0 (glitch rejected).
  - PENDING, on strobe, sample != stable: cnt++. When cnt reaches STABLE_SAMPLES, flip stable, set cnt=0, go to STABLE.
- **P1 select register:** `sel[1:0]` = {P15, P14}, active-low. Loaded from `wr_data[5:4]` on `wr_en`.
- **P1 read nibble (active-low):**
  - dir = ~btn_state[3:0]
  - act = ~btn_state[7:4]
  - nibble = (P14 ? 4'hF : dir) & (P15 ? 4'hF : act)
  - With both lines selected, a bit reads 0 if either of its buttons is pressed. With neither selected, nibble = 4'hF.
- **rd_data** = {2'b11, sel, nibble}.
- **Interrupt:** `nib_q` holds the previous cycle's nibble. `irq` is registered as |(nib_q & ~nibble). A falling edge caused by a select write counts the same as one caused by a button press.

## Timing

- **Reset values:** `sel`=2'b11, all stable states=0, filters in STABLE, prescaler=0, `nib_q`=4'hF, synchronizers=0.
  - Resulting outputs: `rd_data`=8'hFF, `btn_state`=8'h00, `irq`=0.
- **Reset mid-operation:** PENDING counts are discarded and the prescaler restarts at 0.
- **Press latency**, from `btn_raw` edge to `btn_state` change: at least 2+(STABLE_SAMPLES-1)·SAMPLE_DIV+1 cycles and at most 2+STABLE_SAMPLES·SAMPLE_DIV cycles. Release has the same latency.
- **`rd_data` vs `btn_state`:** `rd_data` reflects a `btn_state` change in the same cycle.
- **`rd_data` vs `wr_en`:** `rd_data` reflects a write in the cycle after `wr_en`.
- **`irq` latency:** `irq` asserts exactly one cycle after the cycle in which the nibble falls, and lasts exactly one cycle.
- **Simultaneous events:** a write and a button flip in the same cycle are evaluated together against `nib_q`, producing at most one pulse.
- **Held buttons:** no repeated pulses while a button remains held.

## Configuration

- Macro: `JOYPAD_IRQ_EN`.
  - **Defined:** `nib_q` and the irq logic are compiled in, and `irq` behaves as described above.
  - **Undefined:** `irq` is tied to 0 and `nib_q` is not instantiated. All other behaviour is identical.

## Structure

- **Package `joypad_pkg`:**
  - Button index constants (BTN_RIGHT..BTN_START).
  - Filter state enum `filt_state_t` {STABLE, PENDING}.
  - P1 bit positions (P1_SEL_DIR=4, P1_SEL_ACT=5).
  - P1 reset value 8'hFF.
- **Sub-module `button_filter`:** contains one synchronizer and one filter FSM. Ports: `clk`, `reset`, `strobe`, `raw`, `stable`. It is instantiated 8 times via a generate loop.
- **Top level:** holds the prescaler, `sel`, the read mux and the irq logic.

## Test plan

All scenarios use SAMPLE_DIV=4, STABLE_SAMPLES=3, with `JOYPAD_IRQ_EN` defined unless noted.

1. **Reset:** assert `reset` for 2 cycles, including once while A is PENDING. Required: `rd_data`=8'hFF, `btn_state`=8'h00, `irq`=0, and A does not flip early after release.
2. **Glitch rejection:** hold `btn_raw[4]` high for 6 cycles (≤2 strobes), then low. Required: `btn_state` stays 8'h00 and `irq` never pulses.
3. **Press and action select:** write 8'h10, then hold A. Required: `btn_state[4]` rises within 14 cycles of the press, `rd_data` becomes 8'hDE, and `irq` pulses exactly once, one cycle after the change.
4. **Both lines selected:** write 8'h00, hold right and B. Required: `rd_data`=8'hCC. Then write 8'h30. Required: `rd_data`=8'hFF and no `irq`.
5. **Write-induced edge:** hold up with `sel`=2'b11, then write 8'h20. Required: `rd_data`=8'hEB next cycle and a single `irq` pulse.
6. **Macro off:** rebuild without `JOYPAD_IRQ_EN` and rerun scenario 3. Required: `irq` stays 0 and all `rd_data` values are unchanged.
